// File: rtl/mem_size_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_size_sequencer
// Description : Multicycle sequencer for sized memory accesses (word, half,
//               byte; load and store) on a 32-bit word-wide memory port.
//               Loads are lane-extracted and sign/zero extended into a
//               registered result. Sub-word stores are done as
//               read-modify-write.
//               Optional alignment checking is enabled by defining
//               MEM_SIZE_SEQ_ALIGN_CHK_EN. When it is enabled, a misaligned
//               access skips memory and completes with 'misaligned' set.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_size_sequencer #(
    parameter int MEM_LAT = 1,   // read latency in cycles (>= 1)
    parameter int ADDR_W  = 32   // byte-address width
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              is_signed,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              misaligned
);

    // Read-cycle counter: counts 0 .. MEM_LAT-1 while in READ
    localparam int                 c_CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // Access size encodings (2'b11 is reserved and behaves as a word)
    localparam logic [1:0] c_SZ_WORD = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    // Request fields latched at accept; they stay stable for the whole access
    logic                r_is_store;
    logic [1:0]          r_size;
    logic                r_is_signed;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;

    logic [31:0]         r_word;      // memory word captured on the last READ cycle
    logic [c_CNT_W-1:0]  r_cnt;
    logic [31:0]         r_rdata;

    logic                w_accept;
    logic                w_in_sub_word;
    logic                w_align_err;
    logic                w_read_last;
    logic [15:0]         w_lane_half;
    logic [7:0]          w_lane_byte;
    logic [31:0]         w_load_ext;
    logic [31:0]         w_store_word;

    // A new request is only taken in IDLE, so a start while busy (and in
    // the DONE cycle) is dropped rather than queued.
    assign w_accept      = (r_state == S_IDLE) && start;
    assign w_in_sub_word = (size == c_SZ_HALF) || (size == c_SZ_BYTE);
    assign w_read_last   = (r_state == S_READ) && (r_cnt == c_CNT_LAST);

`ifdef MEM_SIZE_SEQ_ALIGN_CHK_EN
    // Halfwords need addr[0]=0; words (including reserved size) need addr[1:0]=0
    assign w_align_err = ((size == c_SZ_HALF) && addr[0]) ||
                         (((size == c_SZ_WORD) || (size == 2'b11)) && (addr[1:0] != 2'b00));
`else
    assign w_align_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_align_err) begin
                        w_next_state = S_DONE;
                    end else if (!is_store || w_in_sub_word) begin
                        // loads and read-modify-write stores fetch first
                        w_next_state = S_READ;
                    end else begin
                        w_next_state = S_WRITE;
                    end
                end
            end
            S_READ: begin
                if (w_read_last) begin
                    w_next_state = r_is_store ? S_WRITE : S_DONE;
                end
            end
            S_WRITE: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs; write data is forced to zero outside WRITE
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = 32'h0000_0000;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_READ: begin
                busy = 1'b1;
            end
            S_WRITE: begin
                busy      = 1'b1;
                mem_wr    = 1'b1;
                mem_wdata = w_store_word;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Little-endian lane selection from the incoming read word
    always_comb begin
        w_lane_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_addr[1:0])
            2'd0:    w_lane_byte = mem_rdata[7:0];
            2'd1:    w_lane_byte = mem_rdata[15:8];
            2'd2:    w_lane_byte = mem_rdata[23:16];
            default: w_lane_byte = mem_rdata[31:24];
        endcase
    end

    // Sign/zero extension of the selected lane; words pass through
    always_comb begin
        case (r_size)
            c_SZ_HALF: w_load_ext = {{16{r_is_signed & w_lane_half[15]}}, w_lane_half};
            c_SZ_BYTE: w_load_ext = {{24{r_is_signed & w_lane_byte[7]}}, w_lane_byte};
            default:   w_load_ext = mem_rdata;
        endcase
    end

    // Store word: full word, or the fetched word with one lane replaced
    always_comb begin
        w_store_word = r_word;
        case (r_size)
            c_SZ_HALF: begin
                if (r_addr[1]) begin
                    w_store_word[31:16] = r_wdata[15:0];
                end else begin
                    w_store_word[15:0]  = r_wdata[15:0];
                end
            end
            c_SZ_BYTE: begin
                case (r_addr[1:0])
                    2'd0:    w_store_word[7:0]   = r_wdata[7:0];
                    2'd1:    w_store_word[15:8]  = r_wdata[7:0];
                    2'd2:    w_store_word[23:16] = r_wdata[7:0];
                    default: w_store_word[31:24] = r_wdata[7:0];
                endcase
            end
            default: begin
                w_store_word = r_wdata;
            end
        endcase
    end

    // Request latch, read counter, captured word and registered load result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_store  <= 1'b0;
            r_size      <= 2'b00;
            r_is_signed <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'h0000_0000;
            r_word      <= 32'h0000_0000;
            r_cnt       <= '0;
            r_rdata     <= 32'h0000_0000;
        end else begin
            if (w_accept) begin
                r_is_store  <= is_store;
                r_size      <= size;
                r_is_signed <= is_signed;
                r_addr      <= addr;
                r_wdata     <= wdata;
                r_cnt       <= '0;
            end else if (r_state == S_READ) begin
                if (w_read_last) begin
                    r_word <= mem_rdata;
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end
            // rdata only changes on the transition into DONE of a load
            if (w_read_last && !r_is_store) begin
                r_rdata <= w_load_ext;
            end
        end
    end

    assign mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
    assign rdata    = r_rdata;

`ifdef MEM_SIZE_SEQ_ALIGN_CHK_EN
    logic r_misal;

    // Remember whether the accepted request failed the alignment check
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misal <= 1'b0;
        end else if (w_accept) begin
            r_misal <= w_align_err;
        end
    end

    assign misaligned = (r_state == S_DONE) && r_misal;
`else
    assign misaligned = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_size_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_size_sequencer
// Description : Self-checking bench for mem_size_sequencer. Two instances run
//               side by side (MEM_LAT=1 and MEM_LAT=3), each with its own
//               word memory. Expected results come from an arithmetic
//               reference model of the access rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_size_sequencer;

`ifdef MEM_SIZE_SEQ_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_init;

    logic        start_s     [2];
    logic        is_store_s  [2];
    logic [1:0]  size_s      [2];
    logic        is_signed_s [2];
    logic [31:0] addr_s      [2];
    logic [31:0] wdata_s     [2];
    logic [31:0] mem_rdata_s [2];
    logic [31:0] mem_addr_s  [2];
    logic        mem_wr_s    [2];
    logic [31:0] mem_wdata_s [2];
    logic [31:0] rdata_s     [2];
    logic        busy_s      [2];
    logic        done_s      [2];
    logic        misaligned_s[2];

    logic [31:0] mem         [2][16];
    logic [31:0] model_mem   [2][16];
    logic [31:0] model_rdata [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            mem_size_sequencer #(
                .MEM_LAT ((g == 0) ? 1 : 3),
                .ADDR_W  (32)
            ) u_dut (
                .clk        (clk),
                .reset      (reset),
                .start      (start_s[g]),
                .is_store   (is_store_s[g]),
                .size       (size_s[g]),
                .is_signed  (is_signed_s[g]),
                .addr       (addr_s[g]),
                .wdata      (wdata_s[g]),
                .mem_rdata  (mem_rdata_s[g]),
                .mem_addr   (mem_addr_s[g]),
                .mem_wr     (mem_wr_s[g]),
                .mem_wdata  (mem_wdata_s[g]),
                .rdata      (rdata_s[g]),
                .busy       (busy_s[g]),
                .done       (done_s[g]),
                .misaligned (misaligned_s[g])
            );
        end
    endgenerate

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h8899_AABB;
        return (32'(i) * 32'h0103_0507) ^ 32'hA5C3_1E78;
    endfunction

    // Memory read port: the address is stable for the whole access
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            mem_rdata_s[g] = mem[g][mem_addr_s[g][5:2]];
        end
    end

    // Memory write port and initial fill
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (mem_init) begin
                for (int i = 0; i < 16; i++) mem[g][i] <= init_word(i);
            end else if (mem_wr_s[g]) begin
                mem[g][mem_addr_s[g][5:2]] <= mem_wdata_s[g];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Load result from a word: shift the lane down, mask, subtract for sign
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input bit sg, input logic [1:0] lo);
        logic [31:0] v;
        if (sz == 2'b01) begin
            v = (w >> (lo[1] ? 16 : 0)) & 32'h0000_FFFF;
            if (sg && v >= 32'h8000) v = v - 32'h1_0000;
        end else if (sz == 2'b10) begin
            v = (w >> (8 * int'(lo))) & 32'h0000_00FF;
            if (sg && v >= 32'h80) v = v - 32'h100;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Stored word: mask out the target lane and OR in the new data
    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [31:0] wd, input logic [1:0] lo);
        int          sh;
        logic [31:0] m;
        if (sz == 2'b01) begin
            sh = lo[1] ? 16 : 0;
            m  = 32'h0000_FFFF << sh;
            return (w & ~m) | ((wd & 32'h0000_FFFF) << sh);
        end else if (sz == 2'b10) begin
            sh = 8 * int'(lo);
            m  = 32'h0000_00FF << sh;
            return (w & ~m) | ((wd & 32'h0000_00FF) << sh);
        end
        return wd;
    endfunction

    // One complete access on DUT d, checked cycle by cycle against the model.
    // With 'extra' set, start is held high from the cycle after accept through
    // the done cycle with a different address; none of it may be accepted.
    task automatic do_access(input int d, input bit st, input logic [1:0] sz, input bit sg,
                             input logic [31:0] a, input logic [31:0] wd, input bit extra);
        int          lat_cfg;
        int          idx;
        bit          word_sz;
        bit          err;
        int          lat;
        int          wcyc;
        logic [31:0] old_w;
        logic [31:0] new_w;
        logic [31:0] prev_rd;
        logic [31:0] exp_addr;
        string       t;

        lat_cfg  = (d == 0) ? 1 : 3;
        idx      = int'(a[5:2]);
        word_sz  = (sz == 2'b00) || (sz == 2'b11);
        err      = ALIGN_CHK && (((sz == 2'b01) && a[0]) || (word_sz && (a[1:0] != 2'b00)));
        old_w    = model_mem[d][idx];
        new_w    = old_w;
        prev_rd  = model_rdata[d];
        exp_addr = {a[31:2], 2'b00};

        if (err) begin
            lat = 1; wcyc = -1;
        end else if (!st) begin
            lat = lat_cfg + 1; wcyc = -1;
        end else if (word_sz) begin
            lat = 2; wcyc = 1;
        end else begin
            lat = lat_cfg + 2; wcyc = lat_cfg + 1;
        end

        if (st && !err) begin
            new_w = ref_store(old_w, sz, wd, a[1:0]);
            model_mem[d][idx] = new_w;
        end
        if (!st && !err) model_rdata[d] = ref_load(old_w, sz, sg, a[1:0]);

        @(negedge clk);
        start_s[d]     = 1'b1;
        is_store_s[d]  = st;
        size_s[d]      = sz;
        is_signed_s[d] = sg;
        addr_s[d]      = a;
        wdata_s[d]     = wd;
        @(posedge clk);
        #1;
        start_s[d] = extra;
        addr_s[d]  = a ^ 32'h0000_0024;
        wdata_s[d] = ~wd;

        for (int c = 1; c <= lat + 2; c++) begin
            @(negedge clk);
            t = $sformatf("d%0d a=%02h st=%0d sz=%0d c%0d", d, a[5:0], st, sz, c);
            check({t, " busy"},  32'(busy_s[d]),   32'(c <= lat));
            check({t, " done"},  32'(done_s[d]),   32'(c == lat));
            check({t, " mem_wr"}, 32'(mem_wr_s[d]), 32'(c == wcyc));
            check({t, " mem_wdata"}, mem_wdata_s[d], (c == wcyc) ? new_w : 32'h0);
            check({t, " misaligned"}, 32'(misaligned_s[d]), 32'((c == lat) && err));
            check({t, " rdata"}, rdata_s[d], (c >= lat) ? model_rdata[d] : prev_rd);
            if (c <= lat) check({t, " mem_addr"}, mem_addr_s[d], exp_addr);
            start_s[d] = extra && (c < lat);
        end
        start_s[d] = 1'b0;
    endtask

    // Safety net in case the run never reaches its summary
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        mem_init = 1'b1;
        for (int g = 0; g < 2; g++) begin
            start_s[g]     = 1'b0;
            is_store_s[g]  = 1'b0;
            size_s[g]      = 2'b00;
            is_signed_s[g] = 1'b0;
            addr_s[g]      = 32'h0;
            wdata_s[g]     = 32'h0;
            model_rdata[g] = 32'h0;
            for (int i = 0; i < 16; i++) model_mem[g][i] = init_word(i);
        end
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("reset d%0d busy", g),       32'(busy_s[g]),       32'h0);
            check($sformatf("reset d%0d done", g),       32'(done_s[g]),       32'h0);
            check($sformatf("reset d%0d mem_wr", g),     32'(mem_wr_s[g]),     32'h0);
            check($sformatf("reset d%0d mem_wdata", g),  mem_wdata_s[g],       32'h0);
            check($sformatf("reset d%0d mem_addr", g),   mem_addr_s[g],        32'h0);
            check($sformatf("reset d%0d rdata", g),      rdata_s[g],           32'h0);
            check($sformatf("reset d%0d misaligned", g), 32'(misaligned_s[g]), 32'h0);
        end
        reset    = 1'b0;
        mem_init = 1'b0;

        // Directed loads / stores, MEM_LAT=1
        do_access(0, 1'b0, 2'b10, 1'b1, 32'h11, 32'h0, 1'b0);
        check("tp byte signed", rdata_s[0], 32'hFFFF_FFAA);
        do_access(0, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b0);
        check("tp byte unsigned", rdata_s[0], 32'h0000_00AA);
        do_access(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0);
        check("tp half signed", rdata_s[0], 32'hFFFF_8899);
        do_access(0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0);
        check("tp word", rdata_s[0], 32'h8899_AABB);
        do_access(0, 1'b1, 2'b10, 1'b0, 32'h13, 32'h0000_00CC, 1'b0);
        check("tp byte store mem", mem[0][4], 32'hCC99_AABB);
        check("tp store keeps rdata", rdata_s[0], 32'h8899_AABB);
        do_access(0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h1234_5678, 1'b1);
        check("tp word store mem", mem[0][8], 32'h1234_5678);
        do_access(0, 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0);
`ifndef MEM_SIZE_SEQ_ALIGN_CHK_EN
        check("tp unaligned word load", rdata_s[0], 32'hCC99_AABB);
`endif

        // Directed half store with MEM_LAT=3
        do_access(1, 1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_BEEF, 1'b0);
        check("tp half store mem", mem[1][4], 32'h8899_BEEF);

        // Reset in the middle of READ abandons the access at once
        @(negedge clk);
        start_s[1]     = 1'b1;
        is_store_s[1]  = 1'b1;
        size_s[1]      = 2'b01;
        is_signed_s[1] = 1'b0;
        addr_s[1]      = 32'h10;
        wdata_s[1]     = 32'h0000_1111;
        @(posedge clk);
        #1 start_s[1] = 1'b0;
        @(negedge clk);
        check("rst-mid busy before", 32'(busy_s[1]), 32'h1);
        #1 reset = 1'b1;
        #1;
        check("rst-mid busy",   32'(busy_s[1]),   32'h0);
        check("rst-mid mem_wr", 32'(mem_wr_s[1]), 32'h0);
        check("rst-mid done",   32'(done_s[1]),   32'h0);
        check("rst-mid rdata0", rdata_s[0],       32'h0);
        model_rdata[0] = 32'h0;
        model_rdata[1] = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("rst-after c%0d done", c),   32'(done_s[1]),   32'h0);
            check($sformatf("rst-after c%0d mem_wr", c), 32'(mem_wr_s[1]), 32'h0);
            check($sformatf("rst-after c%0d busy", c),   32'(busy_s[1]),   32'h0);
        end
        check("rst-after mem kept", mem[1][4], 32'h8899_BEEF);

        // Randomised accesses on both latencies
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 50; n++) begin
                do_access(d, bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          bit'($urandom_range(0, 1)), 32'($urandom_range(0, 63)),
                          $urandom, ($urandom_range(0, 3) == 0));
            end
            for (int i = 0; i < 16; i++) begin
                check($sformatf("final mem d%0d w%0d", d, i), mem[d][i], model_mem[d][i]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_size_sequencer.md
Name: mem_size_sequencer

Overview:
- Multicycle controller that sequences every sized memory access (word/half/byte, load/store) issued by the main control unit.
- Drives the 32-bit word-wide memory port.
- Performs byte-lane extraction with sign or zero extension on loads.
- Performs read-modify-write for byte and halfword stores.
- Sits between the control FSM and data memory; its load result feeds the write-back select path.

Parameters:
- MEM_LAT, 1: memory read latency in cycles (>=1). mem_rdata is valid MEM_LAT cycles after a read address is presented.
- ADDR_W, 32: byte-address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- size  input  2  00 word, 01 half, 10 byte, 11 reserved (treated as word).
- is_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  input  ADDR_W  byte address.
- wdata  input  32  store data; the low 8/16 bits are used for byte/half.
- mem_rdata  input  32  memory read word.
- mem_addr  output  ADDR_W  word-aligned address, {addr_q[ADDR_W-1:2],2'b00}.
- mem_wr  output  1  memory write strobe.
- mem_wdata  output  32  word written to memory.
- rdata  output  32  extended load result.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- misaligned  output  1  alignment error flag (optional feature).

Behaviour:
- Reset (asynchronous, immediate): state = IDLE; all outputs 0; latched addr/wdata/size/op registers cleared.
- Reset mid-operation: the access is abandoned, mem_wr drops at once, and no done pulse is produced.
- States: IDLE, READ, WRITE, DONE.
  - IDLE: on start=1, latch is_store, size, is_signed, addr, wdata. Next state:
    - load -> READ
    - store with size 00/11 -> WRITE
    - store with size 01/10 -> READ
  - READ: mem_wr=0 for MEM_LAT cycles, counted by an internal counter that is cleared on entry. On the last cycle, capture mem_rdata into word_q. Then load -> DONE, store -> WRITE.
  - WRITE: exactly one cycle with mem_wr=1.
    - Word store: mem_wdata = wdata_q.
    - Half store: replace lane addr_q[1] (bits [31:16] if 1, else [15:0]) of word_q with wdata_q[15:0].
    - Byte store: replace byte lane addr_q[1:0] (lane k = bits [8k+7:8k]) of word_q with wdata_q[7:0].
    - Next state -> DONE.
  - DONE: done=1 for one cycle, then -> IDLE. busy stays high in DONE.
- Load extraction uses little-endian lanes:
  - half = word_q[16*addr_q[1] +: 16]
  - byte = word_q[8*addr_q[1:0] +: 8]
  - Extend the result to 32 bits per is_signed. A word load passes through unchanged.
- rdata is registered. It updates when entering DONE on a load and holds until the next load completes. Stores do not change rdata.
- Latency, measured from the clock edge that accepts start to the cycle done is high:
  - load: MEM_LAT+1
  - word store: 2
  - sub-word store: MEM_LAT+2
- mem_addr is stable for the whole access. mem_wdata = 0 outside WRITE. mem_wr is never high outside WRITE.
- start while busy=1 is ignored (no queueing). A start in the same cycle as done is also ignored.
- misaligned is 0 whenever the feature is compiled out.

Optional Feature:
- Macro: MEM_SIZE_SEQ_ALIGN_CHK_EN.
- Defined:
  - On start accept, check alignment: half with addr[0]=1, or word with addr[1:0]!=0, is an error.
  - On error, skip READ/WRITE and go directly to DONE with misaligned=1 for that DONE cycle only. mem_wr stays 0 and rdata is unchanged.
- Undefined:
  - No check; low address bits are ignored for word accesses, and addr[0] is ignored for half accesses.
  - misaligned is tied 0.

Test Plan:
- MEM_LAT=1, memory word at 0x10 = 0x8899AABB; load byte signed, addr 0x11 -> done on cycle 2 after accept, rdata = 0xFFFFFFAA; unsigned -> 0x000000AA.
- Same word; load half signed, addr 0x12 -> rdata = 0xFFFF8899; load word, addr 0x10 -> rdata = 0x8899AABB.
- Store byte, addr 0x13, wdata = 0x000000CC -> exactly one mem_wr pulse, mem_addr = 0x10, mem_wdata = 0xCC99AABB, done 3 cycles after accept.
- Store word, addr 0x20, wdata = 0x12345678 -> mem_wr on cycle 1 with mem_wdata = 0x12345678, done on cycle 2; a start pulse during busy is ignored (one access only).
- MEM_LAT=3: half store, addr 0x10, wdata = 0xBEEF -> READ lasts 3 cycles, mem_wdata = 0x8899BEEF, done at cycle 5; assert reset in READ -> busy=0 and mem_wr=0 immediately, no done.
- With MEM_SIZE_SEQ_ALIGN_CHK_EN: load word, addr 0x12 -> done + misaligned on cycle 1, no mem_wr, rdata unchanged; without the macro -> reads 0x10, misaligned = 0.
